// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding, default width,
// and the bit-counter sizing helper.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Counter only needs to reach WIDTH-1; keep at least one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (diff = a - b, LSB first) with start/done handshake.
// Define SERIAL_SUB_OVF_EN to add the registered two's-complement overflow output.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic             borrow_q, borrow_d;
    logic             fs_d, fs_bout;
    logic             load, fin;

    full_subtractor u_fs (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .bin  (brw_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // DONE accepts a new start just like IDLE, giving back-to-back operation.
    assign load = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign fin  = (state_q == ST_SHIFT) && (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        brw_d    = brw_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        if (load) begin
            state_d = ST_SHIFT;
            sa_d    = a;
            sb_d    = b;
            res_d   = '0;
            cnt_d   = '0;
            brw_d   = 1'b0;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    sa_d  = {1'b0, sa_q[WIDTH-1:1]};
                    sb_d  = {1'b0, sb_q[WIDTH-1:1]};
                    res_d = WIDTH'({fs_d, res_q} >> 1);
                    brw_d = fs_bout;
                    cnt_d = cnt_q + CW'(1);
                    if (fin) begin
                        state_d  = ST_DONE;
                        diff_d   = res_d;
                        borrow_d = fs_bout;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            brw_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            brw_q    <= brw_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy   = (state_q == ST_SHIFT);
    assign done   = (state_q == ST_DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_q, b_msb_q, ovf_q;

    // The final serial bit is the result MSB, so overflow is known on the last shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (load) begin
                a_msb_q <= a[WIDTH-1];
                b_msb_q <= b[WIDTH-1];
            end
            if (fin) begin
                ovf_q <= (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
            end
        end
    end

    assign overflow = ovf_q;
`endif

endmodule
